ddr4_mem_model: RTL and testbench

- Simplified single-rank DDR4 memory model that stands in for the board SDRAM behind the MAC/DDR4 system top.
- Decodes DDR4 command pins and tracks open rows in 8 banks.
- Stores 64-bit words in a reduced internal array.
- Returns fixed-latency 8-beat read bursts and accepts 8-beat write bursts with byte masks.
- Single-data-rate simplification: one beat per rising clock.

---
 rtl/ddr4_mem_model.sv | 214 +++++++++++++++++++++
 tb/tb_ddr4_mem_model.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_mem_model.sv
// Simplified single-rank DDR4 SDRAM model for the MAC/DDR4 system top.
// Decodes command pins, tracks open rows in 8 banks, and serves fixed-latency 8-beat
// read and write bursts from a reduced internal array. One data beat per rising clock.
module ddr4_mem_model #(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned CL       = 11,
  parameter int unsigned CWL      = 9
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic        ddr4_reset_n,
  input  logic        ddr4_cke,
  input  logic        ddr4_cs_n,
  input  logic        ddr4_act_n,
  input  logic [16:0] ddr4_adr,
  input  logic [1:0]  ddr4_ba,
  input  logic        ddr4_bg,
  input  logic        ddr4_odt,
  input  logic [7:0]  ddr4_dm_n,
  input  logic [63:0] dq_in,
  output logic [63:0] dq_out,
  output logic        dq_oe,
  output logic [7:0]  dqs_t_out,
  output logic [7:0]  dqs_c_out,
  output logic [7:0]  bank_open,
  output logic        err_state,
  output logic        err_timing
);

  localparam int unsigned AddrW = 3 + ROW_BITS + COL_BITS;
  localparam int unsigned Depth = 1 << AddrW;

  // One in-flight burst: where it goes and whether it closes the bank when done.
  typedef struct packed {
    logic                valid;
    logic [2:0]          bank;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic                ap;
  } burst_t;

  // Board SDRAM contents survive reset; only power-up clears them.
  logic [63:0] mem [Depth] = '{default: '0};

  logic                rst;
  logic [7:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] bank_row_q [8];
  logic                err_state_q, err_timing_q;
  logic [2:0]          ccd_cnt_q;

  burst_t              rd_pipe_q [CL];
  burst_t              wr_pipe_q [CWL];
  burst_t              rd_eng_q, wr_eng_q;
  logic [2:0]          rd_beat_q, wr_beat_q;

  logic [63:0]         dq_out_q;
  logic                dq_oe_q;
  logic [7:0]          dqs_t_q, dqs_c_q;

  logic                cmd_en, is_act, is_pre, is_rd, is_wr;
  logic [2:0]          cmd_bank;
  logic                bank_hit, ccd_ok, rd_accept, wr_accept;
  burst_t              rd_new, wr_new, rd_cur, wr_cur;
  logic [2:0]          rd_cur_beat, wr_cur_beat;
  logic [AddrW-1:0]    rd_idx, wr_idx;
  logic                rd_last_ap, wr_last_ap;

  logic                unused_ok;
  assign unused_ok = ^{ddr4_odt, ddr4_adr};

  assign rst = sys_reset | ~ddr4_reset_n;

  // Command decode and acceptance (open bank and tCCD spacing).
  always_comb begin
    cmd_bank  = {ddr4_bg, ddr4_ba};
    cmd_en    = ddr4_cke & ~ddr4_cs_n;
    is_act    = cmd_en & ~ddr4_act_n;
    is_pre    = cmd_en & ddr4_act_n & (ddr4_adr[16:14] == 3'b010);
    is_wr     = cmd_en & ddr4_act_n & (ddr4_adr[16:14] == 3'b100);
    is_rd     = cmd_en & ddr4_act_n & (ddr4_adr[16:14] == 3'b101);
    bank_hit  = bank_open_q[cmd_bank];
    ccd_ok    = (ccd_cnt_q == 3'd0);
    rd_accept = is_rd & bank_hit & ccd_ok;
    wr_accept = is_wr & bank_hit & ccd_ok;

    rd_new       = '0;
    rd_new.valid = rd_accept;
    rd_new.bank  = cmd_bank;
    rd_new.row   = bank_row_q[cmd_bank];
    rd_new.col   = ddr4_adr[COL_BITS-1:0] & ~COL_BITS'(7);
    rd_new.ap    = ddr4_adr[10];
    wr_new       = rd_new;
    wr_new.valid = wr_accept;
  end

  // Current beat per direction: a burst leaving the delay line starts at beat 0,
  // otherwise the running burst engine supplies the next beat.
  always_comb begin
    rd_cur      = rd_eng_q;
    rd_cur_beat = rd_beat_q;
    if (rd_pipe_q[CL-1].valid) begin
      rd_cur      = rd_pipe_q[CL-1];
      rd_cur_beat = 3'd0;
    end
    wr_cur      = wr_eng_q;
    wr_cur_beat = wr_beat_q;
    if (wr_pipe_q[CWL-1].valid) begin
      wr_cur      = wr_pipe_q[CWL-1];
      wr_cur_beat = 3'd0;
    end
    rd_idx     = {rd_cur.bank, rd_cur.row, rd_cur.col | COL_BITS'(rd_cur_beat)};
    wr_idx     = {wr_cur.bank, wr_cur.row, wr_cur.col | COL_BITS'(wr_cur_beat)};
    rd_last_ap = rd_cur.valid & rd_cur.ap & (rd_cur_beat == 3'd7);
    wr_last_ap = wr_cur.valid & wr_cur.ap & (wr_cur_beat == 3'd7);
  end

  // Bank open map: auto-precharge, then PRE, then ACT (ACT wins on a collision).
  always_comb begin
    bank_open_d = bank_open_q;
    if (rd_last_ap) bank_open_d[rd_cur.bank] = 1'b0;
    if (wr_last_ap) bank_open_d[wr_cur.bank] = 1'b0;
    if (is_pre) begin
      if (ddr4_adr[10]) bank_open_d = '0;
      else              bank_open_d[cmd_bank] = 1'b0;
    end
    if (is_act) bank_open_d[cmd_bank] = 1'b1;
  end

  // Bank state, sticky error flags and tCCD spacing counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open_q  <= '0;
      err_state_q  <= 1'b0;
      err_timing_q <= 1'b0;
      ccd_cnt_q    <= 3'd0;
      for (int i = 0; i < 8; i++) bank_row_q[i] <= '0;
    end else begin
      bank_open_q <= bank_open_d;
      if (is_act) bank_row_q[cmd_bank] <= ddr4_adr[ROW_BITS-1:0];
      err_state_q  <= err_state_q | (is_act & bank_hit) | ((is_rd | is_wr) & ~bank_hit);
      err_timing_q <= err_timing_q | ((is_rd | is_wr) & bank_hit & ~ccd_ok);
      if (rd_accept | wr_accept)  ccd_cnt_q <= 3'd7;
      else if (ccd_cnt_q != 3'd0) ccd_cnt_q <= ccd_cnt_q - 3'd1;
    end
  end

  // Latency delay lines for accepted reads and writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CL); i++)  rd_pipe_q[i] <= '0;
      for (int i = 0; i < int'(CWL); i++) wr_pipe_q[i] <= '0;
    end else begin
      rd_pipe_q[0] <= rd_new;
      for (int i = 1; i < int'(CL); i++)  rd_pipe_q[i] <= rd_pipe_q[i-1];
      wr_pipe_q[0] <= wr_new;
      for (int i = 1; i < int'(CWL); i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
    end
  end

  // Burst engines step beats 1..7 after a burst leaves its delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_eng_q  <= '0;
      wr_eng_q  <= '0;
      rd_beat_q <= 3'd0;
      wr_beat_q <= 3'd0;
    end else begin
      if (rd_cur.valid) begin
        rd_eng_q  <= rd_cur;
        rd_beat_q <= rd_cur_beat + 3'd1;
        if (rd_cur_beat == 3'd7) rd_eng_q.valid <= 1'b0;
      end
      if (wr_cur.valid) begin
        wr_eng_q  <= wr_cur;
        wr_beat_q <= wr_cur_beat + 3'd1;
        if (wr_cur_beat == 3'd7) wr_eng_q.valid <= 1'b0;
      end
    end
  end

  // Registered read data and strobes; same-edge write leaves old data on dq_out.
  always_ff @(posedge clk) begin
    if (rst || !rd_cur.valid) begin
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      dqs_t_q  <= 8'h00;
      dqs_c_q  <= 8'h00;
    end else begin
      dq_out_q <= mem[rd_idx];
      dq_oe_q  <= 1'b1;
      dqs_t_q  <= rd_cur_beat[0] ? 8'h00 : 8'hFF;
      dqs_c_q  <= rd_cur_beat[0] ? 8'hFF : 8'h00;
    end
  end

  // Byte-masked write beats into the array; a reset edge drops the beat.
  always_ff @(posedge clk) begin
    if (!rst && wr_cur.valid) begin
      for (int j = 0; j < 8; j++) begin
        if (ddr4_dm_n[j]) mem[wr_idx][8*j +: 8] <= dq_in[8*j +: 8];
      end
    end
  end

  assign dq_out     = dq_out_q;
  assign dq_oe      = dq_oe_q;
  assign dqs_t_out  = dqs_t_q;
  assign dqs_c_out  = dqs_c_q;
  assign bank_open  = bank_open_q;
  assign err_state  = err_state_q;
  assign err_timing = err_timing_q;

endmodule

// File: tb/tb_ddr4_mem_model.sv
// Directed bench for ddr4_mem_model: read beats are predicted from a reference array
// into a scoreboard queue and checked cycle-exact as the model drives them.
module tb_ddr4_mem_model;

  localparam int CL  = 11;
  localparam int CWL = 9;

  logic        clk = 1'b0;
  logic        sys_reset, ddr4_reset_n, ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_bg, ddr4_odt;
  logic [16:0] ddr4_adr;
  logic [1:0]  ddr4_ba;
  logic [7:0]  ddr4_dm_n;
  logic [63:0] dq_in, dq_out;
  logic        dq_oe, err_state, err_timing;
  logic [7:0]  dqs_t_out, dqs_c_out, bank_open;

  always #5 clk = ~clk;

  ddr4_mem_model #(.ROW_BITS(4), .COL_BITS(6), .CL(CL), .CWL(CWL)) dut (
    .clk(clk), .sys_reset(sys_reset), .ddr4_reset_n(ddr4_reset_n), .ddr4_cke(ddr4_cke),
    .ddr4_cs_n(ddr4_cs_n), .ddr4_act_n(ddr4_act_n), .ddr4_adr(ddr4_adr), .ddr4_ba(ddr4_ba),
    .ddr4_bg(ddr4_bg), .ddr4_odt(ddr4_odt), .ddr4_dm_n(ddr4_dm_n), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .dqs_t_out(dqs_t_out), .dqs_c_out(dqs_c_out),
    .bank_open(bank_open), .err_state(err_state), .err_timing(err_timing)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [7:0]  dqs;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [8192];
  logic [3:0]  open_row [8];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock, then check read output against the scoreboard.
  task automatic tick();
    exp_t       e;
    logic       exp_oe;
    logic [7:0] dqs_c_exp;
    @(posedge clk);
    cyc++;
    #1;
    exp_oe = (sb.size() != 0) && (sb[0].cyc == cyc);
    check("dq_oe", 64'(dq_oe), 64'(exp_oe));
    if (dq_oe === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      dqs_c_exp = ~e.dqs;
      check("rd_cycle", 64'(cyc), 64'(e.cyc));
      check("rd_data", dq_out, e.data);
      check("dqs_t", 64'(dqs_t_out), 64'(e.dqs));
      check("dqs_c", 64'(dqs_c_out), 64'(dqs_c_exp));
    end else if (dq_oe !== 1'b1) begin
      check("idle_dq", dq_out, 64'd0);
      check("idle_dqs", 64'({dqs_t_out, dqs_c_out}), 64'd0);
      if (sb.size() != 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic nop();
    ddr4_act_n = 1'b1;
    ddr4_adr   = 17'h1C000;
  endtask

  task automatic do_act(input logic [2:0] bank, input logic [3:0] row);
    ddr4_act_n         = 1'b0;
    {ddr4_bg, ddr4_ba} = bank;
    ddr4_adr           = {13'd0, row};
    open_row[bank]     = row;
    tick();
    nop();
  endtask

  task automatic do_pre(input logic [2:0] bank, input logic all);
    ddr4_act_n         = 1'b1;
    {ddr4_bg, ddr4_ba} = bank;
    ddr4_adr           = '0;
    ddr4_adr[16:14]    = 3'b010;
    ddr4_adr[10]       = all;
    tick();
    nop();
  endtask

  task automatic do_rd(input logic [2:0] bank, input logic [5:0] col, input logic ap,
                       input logic expect_data);
    exp_t        e;
    logic [12:0] idx;
    logic [5:0]  base;
    base               = col & 6'h38;
    ddr4_act_n         = 1'b1;
    {ddr4_bg, ddr4_ba} = bank;
    ddr4_adr           = '0;
    ddr4_adr[16:14]    = 3'b101;
    ddr4_adr[10]       = ap;
    ddr4_adr[5:0]      = col;
    if (expect_data) begin
      for (int k = 0; k < 8; k++) begin
        idx    = {bank, open_row[bank], base | 6'(k)};
        e.cyc  = cyc + 1 + CL + k;
        e.data = ref_mem[idx];
        e.dqs  = (k % 2 == 0) ? 8'hFF : 8'h00;
        sb.push_back(e);
      end
    end
    tick();
    nop();
  endtask

  // Beat k carries d0 + k*step; beat 0 uses mask dm0, later beats dmr.
  task automatic do_wr(input logic [2:0] bank, input logic [5:0] col, input logic [63:0] d0,
                       input logic [63:0] step, input logic [7:0] dm0, input logic [7:0] dmr);
    logic [12:0] idx;
    logic [63:0] d;
    logic [7:0]  m;
    ddr4_act_n         = 1'b1;
    {ddr4_bg, ddr4_ba} = bank;
    ddr4_adr           = '0;
    ddr4_adr[16:14]    = 3'b100;
    ddr4_adr[5:0]      = col;
    tick();
    nop();
    ticks(CWL - 1);
    for (int k = 0; k < 8; k++) begin
      d         = d0 + step * 64'(k);
      m         = (k == 0) ? dm0 : dmr;
      dq_in     = d;
      ddr4_dm_n = m;
      idx       = {bank, open_row[bank], (col & 6'h38) | 6'(k)};
      for (int j = 0; j < 8; j++) if (m[j]) ref_mem[idx][8*j +: 8] = d[8*j +: 8];
      tick();
    end
    dq_in     = '0;
    ddr4_dm_n = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < CL + 24 && sb.size() != 0; i++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) open_row[i] = '0;
    sys_reset    = 1'b1;
    ddr4_reset_n = 1'b1;
    ddr4_cke     = 1'b1;
    ddr4_cs_n    = 1'b0;
    ddr4_odt     = 1'b0;
    ddr4_bg      = 1'b0;
    ddr4_ba      = 2'd0;
    ddr4_dm_n    = '0;
    dq_in        = '0;
    nop();

    // Reset state.
    ticks(2);
    sys_reset = 1'b0;
    check("rst_bank_open", 64'(bank_open), 64'd0);
    check("rst_err_state", 64'(err_state), 64'd0);
    check("rst_err_timing", 64'(err_timing), 64'd0);
    check("rst_dq_oe", 64'(dq_oe), 64'd0);

    // Basic write then read-back of bank 0 row 3 column 8.
    do_act(3'd0, 4'd3);
    check("act_bank_open", 64'(bank_open), 64'h01);
    do_wr(3'd0, 6'd8, 64'h1000, 64'd1, 8'hFF, 8'hFF);
    ticks(2);
    do_rd(3'd0, 6'd8, 1'b0, 1'b1);
    drain();
    check("basic_err_state", 64'(err_state), 64'd0);
    check("basic_err_timing", 64'(err_timing), 64'd0);

    // Byte mask: only low four bytes of beat 0 change.
    do_wr(3'd0, 6'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h0F, 8'h00);
    check("mask_ref_model", ref_mem[{3'd0, 4'd3, 6'd8}], 64'h0000_0000_FFFF_FFFF);
    ticks(2);
    do_rd(3'd0, 6'd10, 1'b0, 1'b1);
    drain();

    // Read to a closed bank is dropped and flags a state error.
    do_rd(3'd5, 6'd0, 1'b0, 1'b0);
    ticks(CL + 10);
    check("closed_err_state", 64'(err_state), 64'd1);
    check("closed_err_timing", 64'(err_timing), 64'd0);

    // ddr4_reset_n clears flags; double ACT to bank 5 sets err_state.
    ddr4_reset_n = 1'b0;
    tick();
    ddr4_reset_n = 1'b1;
    check("pin_rst_err_state", 64'(err_state), 64'd0);
    check("pin_rst_bank_open", 64'(bank_open), 64'd0);
    do_act(3'd0, 4'd3);
    do_act(3'd5, 4'd1);
    check("act_once_err", 64'(err_state), 64'd0);
    do_act(3'd5, 4'd2);
    check("act_twice_err", 64'(err_state), 64'd1);
    check("act_twice_open", 64'(bank_open), 64'h21);

    // tCCD: RD at T and T+4 -> second dropped.
    check("pre_ccd_timing", 64'(err_timing), 64'd0);
    do_rd(3'd0, 6'd8, 1'b0, 1'b1);
    ticks(3);
    do_rd(3'd0, 6'd8, 1'b0, 1'b0);
    check("ccd_err_timing", 64'(err_timing), 64'd1);
    drain();
    ticks(8);

    // RD at T and T+8 -> 16 contiguous beats.
    do_rd(3'd0, 6'd8, 1'b0, 1'b1);
    ticks(7);
    do_rd(3'd0, 6'd16, 1'b0, 1'b1);
    drain();

    // Auto-precharge closes bank 0 on the last beat.
    ticks(2);
    do_rd(3'd0, 6'd8, 1'b1, 1'b1);
    ticks(CL + 6);
    check("ap_before_last", 64'(bank_open), 64'h21);
    tick();
    check("ap_after_last", 64'(bank_open), 64'h20);
    drain();

    // PRE single bank, then PRE all.
    do_act(3'd2, 4'd7);
    check("open_b2", 64'(bank_open), 64'h24);
    do_pre(3'd2, 1'b0);
    check("pre_b2", 64'(bank_open), 64'h20);
    do_pre(3'd0, 1'b1);
    check("pre_all", 64'(bank_open), 64'h00);

    // sys_reset in the middle of a read burst.
    do_act(3'd0, 4'd3);
    ticks(2);
    do_rd(3'd0, 6'd8, 1'b0, 1'b1);
    ticks(CL + 2);
    check("mid_burst_left", 64'(sb.size()), 64'd5);
    sb.delete();
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    check("mid_rst_dq_oe", 64'(dq_oe), 64'd0);
    check("mid_rst_bank_open", 64'(bank_open), 64'd0);
    check("mid_rst_err_state", 64'(err_state), 64'd0);
    check("mid_rst_err_timing", 64'(err_timing), 64'd0);
    ticks(10);
    do_act(3'd0, 4'd3);
    ticks(2);
    do_rd(3'd0, 6'd8, 1'b0, 1'b1);
    drain();
    ticks(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
